// File: rtl/swipe_gesture_encoder.sv
// Swipe gesture encoder: debounces four touch pads (W, E, N, S), detects a
// first-pad / opposite-pad swipe inside a time window and drives the 3-bit
// direction code for the LED wave display for a fixed hold time.
module swipe_gesture_encoder #(
   parameter int CLK_FRE      = 50000000,
   parameter int DEBOUNCE_CYC = 500000,
   parameter int GAP_MAX_CYC  = 25000000,
   parameter int HOLD_CYC     = 10000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] pad_n,
   output logic [2:0] signal,
   output logic       gesture_strobe,
   output logic       busy
);

   // Counter widths; a terminal value of 0 still needs one bit
   localparam int DB_W   = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
   localparam int GAP_W  = (GAP_MAX_CYC  > 1) ? $clog2(GAP_MAX_CYC)  : 1;
   localparam int HOLD_W = (HOLD_CYC     > 1) ? $clog2(HOLD_CYC)     : 1;

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYC - 1);
   localparam logic [DB_W-1:0]   DB_ONE    = DB_W'(1);
   localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_MAX_CYC - 1);
   localparam logic [GAP_W-1:0]  GAP_ONE   = GAP_W'(1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_ARMED   = 2'b01,
      ST_EMIT    = 2'b10,
      ST_RELEASE = 2'b11
   } state_t;

   // Number of simultaneous press events
   function automatic logic [2:0] count_ones(input logic [3:0] v);
      count_ones = {2'b00, v[0]} + {2'b00, v[1]} + {2'b00, v[2]} + {2'b00, v[3]};
   endfunction

   // Direction code named by the pad that started the swipe
   function automatic logic [2:0] code_for(input logic [3:0] first);
      case (first)
         4'b0001: code_for = 3'b010;   // W first -> right
         4'b0010: code_for = 3'b001;   // E first -> left
         4'b0100: code_for = 3'b100;   // N first -> down
         4'b1000: code_for = 3'b011;   // S first -> up
         default: code_for = 3'b000;
      endcase
   endfunction

   logic [3:0]        sync1_r;
   logic [3:0]        sync2_r;
   logic [3:0]        db_r;
   logic [3:0]        db_d_r;
   logic [DB_W-1:0]   db_cnt_r [4];
   logic [3:0]        press_evt_s;
   logic [2:0]        evt_cnt_s;
   logic [3:0]        opp_s;

   state_t            state_r, state_nxt;
   logic [GAP_W-1:0]  gap_r, gap_nxt;
   logic [HOLD_W-1:0] hold_r, hold_nxt;
   logic [3:0]        first_r, first_nxt;
   logic [2:0]        signal_r, signal_nxt;
   logic              strobe_r, strobe_nxt;
   logic              busy_r, busy_nxt;

   // Two-flop synchronizer on the active-high pressed levels
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= 4'b0000;
         sync2_r <= 4'b0000;
      end else begin
         sync1_r <= ~pad_n;
         sync2_r <= sync1_r;
      end
   end

   // Per-pad debounce: flip only after DEBOUNCE_CYC consecutive disagreeing cycles
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < 4; i++) begin
            db_cnt_r[i] <= {DB_W{1'b0}};
         end
         db_r <= 4'b0000;
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (sync2_r[i] == db_r[i]) begin
               db_cnt_r[i] <= {DB_W{1'b0}};
            end else if (db_cnt_r[i] == DB_LAST) begin
               db_r[i]     <= sync2_r[i];
               db_cnt_r[i] <= {DB_W{1'b0}};
            end else begin
               db_cnt_r[i] <= db_cnt_r[i] + DB_ONE;
            end
         end
      end
   end

   // Delayed debounced state for rising-edge (press) detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_d_r <= 4'b0000;
      end else begin
         db_d_r <= db_r;
      end
   end

   assign press_evt_s = db_r & ~db_d_r;
   assign evt_cnt_s   = count_ones(press_evt_s);
   // Opposite pad on the same axis: swap W<->E and N<->S
   assign opp_s       = {first_r[2], first_r[3], first_r[0], first_r[1]};

   // FSM state, counters and registered outputs
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r  <= ST_IDLE;
         gap_r    <= {GAP_W{1'b0}};
         hold_r   <= {HOLD_W{1'b0}};
         first_r  <= 4'b0000;
         signal_r <= 3'b000;
         strobe_r <= 1'b0;
         busy_r   <= 1'b0;
      end else begin
         state_r  <= state_nxt;
         gap_r    <= gap_nxt;
         hold_r   <= hold_nxt;
         first_r  <= first_nxt;
         signal_r <= signal_nxt;
         strobe_r <= strobe_nxt;
         busy_r   <= busy_nxt;
      end
   end

   // Next-state and next-output decode; counters clear on every state change
   always_comb begin
      state_nxt  = state_r;
      gap_nxt    = {GAP_W{1'b0}};
      hold_nxt   = {HOLD_W{1'b0}};
      first_nxt  = first_r;
      signal_nxt = 3'b000;
      strobe_nxt = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (evt_cnt_s == 3'd1) begin
               first_nxt = press_evt_s;
               state_nxt = ST_ARMED;
            end else if (evt_cnt_s >= 3'd2) begin
               state_nxt = ST_RELEASE;
            end else begin
               state_nxt = ST_IDLE;
            end
         end
         ST_ARMED: begin
            if ((evt_cnt_s == 3'd1) && (press_evt_s == opp_s)) begin
               state_nxt  = ST_EMIT;
               signal_nxt = code_for(first_r);
               strobe_nxt = 1'b1;
            end else if (evt_cnt_s != 3'd0) begin
               state_nxt = ST_RELEASE;
            end else if (gap_r == GAP_LAST) begin
               state_nxt = ST_RELEASE;
            end else begin
               gap_nxt   = gap_r + GAP_ONE;
               state_nxt = ST_ARMED;
            end
         end
         ST_EMIT: begin
            if (hold_r == HOLD_LAST) begin
               state_nxt = ST_RELEASE;
            end else begin
               hold_nxt   = hold_r + HOLD_ONE;
               signal_nxt = signal_r;
               state_nxt  = ST_EMIT;
            end
         end
         ST_RELEASE: begin
            if (db_r == 4'b0000) begin
               state_nxt = ST_IDLE;
            end else begin
               state_nxt = ST_RELEASE;
            end
         end
         default: begin
            state_nxt = ST_IDLE;
         end
      endcase
      busy_nxt = (state_nxt != ST_IDLE);
   end

   assign signal         = signal_r;
   assign gesture_strobe = strobe_r;
   assign busy           = busy_r;

endmodule

// File: tb/tb_swipe_gesture_encoder.sv
// Randomized self-checking bench for swipe_gesture_encoder. Each scenario is
// described as pad press/release times; the expected output timeline is
// derived arithmetically from those times and compared every cycle.
module tb_swipe_gesture_encoder;

   localparam int DEB  = 4;
   localparam int GAP  = 20;
   localparam int HOLD = 10;
   localparam int LAT  = 2 + DEB;   // drive cycle -> press event cycle

   logic       clk;
   logic       rst;
   logic [3:0] pad_n;
   logic [2:0] signal;
   logic       gesture_strobe;
   logic       busy;

   int n_chk;
   int n_pass;
   int scn;
   int cur_c;

   // scenario description
   int pd [4];
   int rd [4];
   int gs [8];
   int gl [8];
   int g_pad;
   int g_n;
   bit code_exp;
   bit has_evt;
   logic [2:0] code_v;
   int e1, e2, last_busy, dur;

   swipe_gesture_encoder #(
      .CLK_FRE     (1000),
      .DEBOUNCE_CYC(DEB),
      .GAP_MAX_CYC (GAP),
      .HOLD_CYC    (HOLD)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .pad_n         (pad_n),
      .signal        (signal),
      .gesture_strobe(gesture_strobe),
      .busy          (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s scn=%0d cyc=%0d: got %0h expected %0h", tag, scn, cur_c, got, exp);
      end
   endtask

   // Code displayed when the swipe starts on pad p (W=0,E=1,N=2,S=3)
   function automatic logic [2:0] exp_code(input int p);
      case (p)
         0:       return 3'b010;
         1:       return 3'b001;
         2:       return 3'b100;
         3:       return 3'b011;
         default: return 3'b000;
      endcase
   endfunction

   function automatic int other_axis(input int p);
      return ((p < 2) ? 2 : 0) + int'($urandom_range(0, 1));
   endfunction

   // kind: 0 valid swipe, 1 timeout, 2 other-axis pad, 3 simultaneous, 4 glitches
   task automatic build(input int kind, input int p1_in, input int d_in, input int xtra);
      int p1, p2, p3, d, r_end, z, last_press, t;
      for (int i = 0; i < 4; i++) begin
         pd[i] = -1;
         rd[i] = -1;
      end
      g_n = 0; code_exp = 0; has_evt = 1; code_v = 3'b000;
      e1 = LAT; e2 = 0; r_end = 0; z = 0;
      p1 = (p1_in < 0) ? int'($urandom_range(0, 3)) : p1_in;
      pd[p1] = (kind == 4) ? -1 : 0;
      case (kind)
         0: begin
            d = (d_in < 0) ? int'($urandom_range(1, GAP)) : d_in;
            pd[p1 ^ 1] = d;
            e2 = d + LAT;
            code_exp = 1;
            code_v = exp_code(p1);
            r_end = e2 + HOLD + 1;
            if ((xtra == 1) || ((xtra < 0) && ($urandom_range(0, 1) == 1))) begin
               p3 = other_axis(p1);
               pd[p3] = e2 + int'($urandom_range(1, HOLD)) - LAT;
            end
         end
         1: begin
            if (d_in >= 0) pd[p1 ^ 1] = d_in;
            else if ($urandom_range(0, 1) == 1) pd[p1 ^ 1] = int'($urandom_range(GAP + 1, GAP + 6));
            r_end = LAT + GAP + 1;
         end
         2: begin
            d = (d_in < 0) ? int'($urandom_range(1, GAP)) : d_in;
            pd[other_axis(p1)] = d;
            r_end = d + LAT + 1;
         end
         3: begin
            p2 = (p1 + int'($urandom_range(1, 3))) % 4;
            pd[p2] = 0;
            r_end = LAT + 1;
         end
         default: begin
            has_evt = 0;
            g_pad = p1;
            g_n = int'($urandom_range(1, 4));
            t = 0;
            for (int k = 0; k < g_n; k++) begin
               gs[k] = t;
               gl[k] = int'($urandom_range(1, DEB - 1));
               t = t + gl[k] + int'($urandom_range(2, 5));
            end
            z = t + LAT;
         end
      endcase
      last_press = -1;
      for (int i = 0; i < 4; i++) if (pd[i] > last_press) last_press = pd[i];
      for (int i = 0; i < 4; i++) begin
         if (pd[i] >= 0) begin
            rd[i] = last_press + DEB + 3 + int'($urandom_range(0, 20));
            if (rd[i] + LAT > z) z = rd[i] + LAT;
         end
      end
      last_busy = (r_end > z) ? r_end : z;
      dur = last_busy + 4;
      scn++;
   endtask

   // Play the scenario cycle by cycle; optionally hit rst at cycle abort_at
   task automatic run(input int abort_at);
      logic [3:0] pressed;
      logic [2:0] sig_e;
      for (int c = 0; c < dur; c++) begin
         cur_c = c;
         sig_e = (code_exp && (c >= e2 + 1) && (c <= e2 + HOLD)) ? code_v : 3'b000;
         chk_eq("signal", {5'b00000, signal}, {5'b00000, sig_e});
         chk_eq("strobe", {7'b0000000, gesture_strobe},
                {7'b0000000, (code_exp && (c == e2 + 1))});
         chk_eq("busy", {7'b0000000, busy},
                {7'b0000000, (has_evt && (c >= e1 + 1) && (c <= last_busy))});
         if (c == abort_at) begin
            #2;
            rst = 1'b1;
            pad_n = 4'b1111;
            #1;
            chk_eq("rst_signal", {5'b00000, signal}, 8'h00);
            chk_eq("rst_strobe", {7'b0000000, gesture_strobe}, 8'h00);
            chk_eq("rst_busy", {7'b0000000, busy}, 8'h00);
            @(posedge clk); #3;
            rst = 1'b0;
            repeat (3) begin
               @(posedge clk); #1;
               chk_eq("post_rst_signal", {5'b00000, signal}, 8'h00);
               chk_eq("post_rst_busy", {7'b0000000, busy}, 8'h00);
            end
            return;
         end
         pressed = 4'b0000;
         for (int i = 0; i < 4; i++) begin
            if ((pd[i] >= 0) && (c >= pd[i]) && (c < rd[i])) pressed[i] = 1'b1;
         end
         for (int k = 0; k < g_n; k++) begin
            if ((c >= gs[k]) && (c < gs[k] + gl[k])) pressed[g_pad] = 1'b1;
         end
         pad_n = ~pressed;
         @(posedge clk); #1;
      end
   endtask

   initial begin
      n_chk = 0; n_pass = 0; scn = 0; cur_c = 0;
      rst = 1'b1;
      pad_n = 4'b1111;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("reset_signal", {5'b00000, signal}, 8'h00);
      chk_eq("reset_strobe", {7'b0000000, gesture_strobe}, 8'h00);
      chk_eq("reset_busy", {7'b0000000, busy}, 8'h00);
      #2 rst = 1'b0;
      @(posedge clk); #1;

      build(0, 0, 8, 0);        run(-1);   // W -> E, right
      build(0, 3, 5, 0);        run(-1);   // S -> N, up
      build(0, 1, 8, 0);        run(-1);   // E -> W, left
      build(0, 2, 8, 0);        run(-1);   // N -> S, down
      build(0, 0, GAP, 0);      run(-1);   // second press on the last gap cycle
      build(1, 0, GAP + 1, 0);  run(-1);   // one cycle too late
      build(1, 0, GAP + 5, 0);  run(-1);   // timeout, then E while W held
      build(2, 0, 3, 0);        run(-1);   // W then N
      build(3, 0, -1, 0);       run(-1);   // simultaneous
      build(4, 1, -1, 0);       run(-1);   // short glitches on E
      build(0, 0, 8, 1);        run(-1);   // extra pad pressed during EMIT
      build(0, 0, 8, 0);        run(LAT + 8 + 1 + 4);   // reset at hold cycle 4
      build(0, 0, 8, 0);        run(-1);   // fresh swipe after reset

      repeat (60) begin
         build(int'($urandom_range(0, 4)), -1, -1, -1);
         run(-1);
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
